// File: rtl/level_alarm_ctrl.sv
// level_alarm_ctrl: water-level alarm/pump controller with tick-confirmed hysteresis.
// Optional tick watchdog is enabled by defining TICK_WDOG_EN.
module level_alarm_ctrl #(
    parameter int LEVEL_W       = 8,
    parameter int WARN_HI       = 150,
    parameter int WARN_LO       = 140,
    parameter int ALARM_HI      = 200,
    parameter int ALARM_LO      = 190,
    parameter int CONFIRM_TICKS = 4,
    parameter int SILENCE_TICKS = 60,
    parameter int WDOG_CYCLES   = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               blink_in,
    input  logic [LEVEL_W-1:0] level,
    input  logic               ack,
    output logic [1:0]         state,
    output logic               pump_on,
    output logic               alarm_led,
    output logic               buzzer,
    output logic               tick_fault
);
    typedef enum logic [1:0] {NORMAL, WARN, ALARM, SILENCED} state_t;
    localparam int CW = $clog2(CONFIRM_TICKS + 1);
    localparam int SW = $clog2(SILENCE_TICKS + 1);
    localparam logic [CW-1:0] CONF = CW'(CONFIRM_TICKS);
    localparam logic [SW-1:0] SIL = SW'(SILENCE_TICKS);
    localparam logic [LEVEL_W-1:0] W_HI = LEVEL_W'(WARN_HI);
    localparam logic [LEVEL_W-1:0] W_LO = LEVEL_W'(WARN_LO);
    localparam logic [LEVEL_W-1:0] A_HI = LEVEL_W'(ALARM_HI);
    localparam logic [LEVEL_W-1:0] A_LO = LEVEL_W'(ALARM_LO);
    state_t cur, nxt;
    logic [CW-1:0] conf_cnt, conf_nx, conf_inc, base;
    logic [SW-1:0] sil_cnt, sil_nx, sil_inc;
    logic blink_d, tick, dir, dir_nx, cond, fault_nx;
    logic lvl_w_hi, lvl_w_lo, lvl_a_hi, lvl_a_lo;
`ifdef TICK_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(WDOG_CYCLES - 1);
    logic [WW-1:0] wd_cnt, wd_nx;
`endif
    assign tick = blink_in ^ blink_d;
    assign state = cur;
    assign lvl_w_hi = level >= W_HI;
    assign lvl_w_lo = level < W_LO;
    assign lvl_a_hi = level >= A_HI;
    assign lvl_a_lo = level < A_LO;
    always_comb begin
        cond = cur == NORMAL ? lvl_w_hi : cur == WARN ? (lvl_a_hi | lvl_w_lo) : lvl_a_lo;
        // in WARN a flip between the up and down condition restarts confirmation
        base = (cur == WARN && lvl_w_lo != dir) ? '0 : conf_cnt;
        conf_inc = base == CONF ? base : base + 1'b1;
        sil_inc = sil_cnt == SIL ? sil_cnt : sil_cnt + 1'b1;
        nxt = cur;
        conf_nx = tick ? (cond ? conf_inc : '0) : conf_cnt;
        sil_nx = tick ? sil_inc : sil_cnt;
        dir_nx = tick && cond ? lvl_w_lo : dir;
        fault_nx = 1'b0;
        if (cur == ALARM && ack)
            nxt = SILENCED;
        else if (tick && cond && conf_inc == CONF)
            nxt = cur == NORMAL ? (lvl_a_hi ? ALARM : WARN) :
                  cur == WARN   ? (lvl_a_hi ? ALARM : NORMAL) : WARN;
        else if (cur == SILENCED && tick && sil_inc == SIL)
            nxt = ALARM;
`ifdef TICK_WDOG_EN
        wd_nx = tick ? '0 : (wd_cnt == WD_MAX ? wd_cnt : wd_cnt + 1'b1);
        fault_nx = tick_fault ? !tick : (!tick && wd_cnt == WD_MAX);
        // the fault-clearing tick only re-arms; level rules resume on later ticks
        if (tick_fault || fault_nx) begin
            nxt = ALARM;
            conf_nx = '0;
            sil_nx = '0;
            dir_nx = 1'b0;
        end
`endif
        if (nxt != cur) begin
            conf_nx = '0;
            sil_nx = '0;
            dir_nx = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur <= NORMAL;
            blink_d <= blink_in;
            conf_cnt <= '0;
            sil_cnt <= '0;
            dir <= 1'b0;
            pump_on <= 1'b0;
            alarm_led <= 1'b0;
            buzzer <= 1'b0;
        end else begin
            cur <= nxt;
            blink_d <= blink_in;
            conf_cnt <= conf_nx;
            sil_cnt <= sil_nx;
            dir <= dir_nx;
            pump_on <= nxt != NORMAL;
            alarm_led <= nxt == WARN ? blink_in : (nxt == ALARM || nxt == SILENCED);
            buzzer <= fault_nx | (nxt == ALARM && blink_in);
        end
    end
`ifdef TICK_WDOG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            tick_fault <= 1'b0;
        end else begin
            wd_cnt <= wd_nx;
            tick_fault <= fault_nx;
        end
    end
`else
    assign tick_fault = 1'b0;
`endif
endmodule
